btb_update_ctrl: RTL
====================

Name: btb_update_ctrl

Overview:
- Sequences all writes into the 2-way set-associative BTB arrays.
- Accepts resolved-branch updates from EX through a small queue and performs a read-tag/decide/write sequence on each.
- Owns the per-set LRU bits and runs a full invalidate sweep on flush.
- Fetch lookups always have priority on the shared single-port arrays; this controller yields to them.

Parameters:
ADDR_WIDTH, 32, width of branch target address
OFFSET_WIDTH, 4, PC offset bits below index
INDEX_WIDTH, 3, set index bits (8 sets)
BRANCH_PC, 10, PC bits used by BTB
TAG_WIDTH, BRANCH_PC-OFFSET_WIDTH-INDEX_WIDTH (3), stored tag width
QUEUE_DEPTH, 2, update queue entries

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
upd_valid  in  1  EX presents resolved branch
upd_ready  out  1  queue can accept (= !full && !rst)
upd_pc  in  BRANCH_PC  branch PC
upd_target  in  ADDR_WIDTH  resolved target
upd_taken  in  1  branch resolved taken
lookup_active  in  1  fetch owns array port this cycle
lu_hit_valid  in  1  fetch lookup hit (LRU touch)
lu_hit_index  in  INDEX_WIDTH  set of fetch hit
lu_hit_way  in  1  way of fetch hit
inv_req  in  1  pulse: invalidate whole BTB
inv_busy  out  1  sweep pending/in progress
arr_rd_en  out  1  tag read strobe; data valid next cycle
arr_rd_index  out  INDEX_WIDTH  read set
arr_rd_tag0, arr_rd_tag1  in  TAG_WIDTH each  way tags (1-cycle latency)
arr_rd_vld0, arr_rd_vld1  in  1 each  way valid bits
arr_wr_en  out  1  array write strobe
arr_wr_way  out  1  way written
arr_wr_index  out  INDEX_WIDTH  set written
arr_wr_tag  out  TAG_WIDTH  tag written
arr_wr_target  out  ADDR_WIDTH  target written
arr_wr_vld  out  1  valid bit written

Behaviour:
- Field extraction: index = pc[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH]; tag = pc[BRANCH_PC-1:OFFSET_WIDTH+INDEX_WIDTH].
- Reset: queue empty, state IDLE, all LRU bits 0, inv pending 0. All outputs 0, including upd_ready.
- Queue: FIFO of {pc, target, taken}. Push on upd_valid&&upd_ready. Push and pop in the same cycle are legal. No push when full.
- IDLE:
  - If inv pending and !lookup_active, go to INV with sweep counter 0.
  - Else if queue non-empty and !lookup_active, assert arr_rd_en with the head index and go to RD_WAIT.
  - If lookup_active, the FSM holds and no strobe is issued.
- RD_WAIT: capture tags and select a way.
  - hit0 = vld0 && tag0==head tag; hit1 is the same for way 1. Both hit: way0 wins.
  - taken && hit: overwrite the hit way.
  - taken && miss: use the first invalid way (way0 first). If both are valid, use victim = lru[index].
  - !taken && hit: write vld=0 to the hit way.
  - !taken && miss: pop the head, back to IDLE, no write.
  - Otherwise go to WRITE.
- WRITE:
  - If lookup_active, hold with all arr_wr_* stable and arr_wr_en=0.
  - Else assert arr_wr_en for one cycle and pop the head.
  - Set lru[index] = ~way on a valid write. On an invalidating write, set lru[index] = way.
  - Return to IDLE.
- Uncontended latency: accepted at edge T, arr_rd_en in cycle T+1, arr_wr_en in cycle T+3. Next update read no earlier than T+4.
- INV:
  - One write per non-stalled cycle: vld=0, index=cnt[INDEX_WIDTH:1], way=cnt[0]. 2^(INDEX_WIDTH+1) = 16 writes total.
  - Stall on lookup_active.
  - After the last write, clear all LRU bits, clear pending, and return to IDLE.
- inv_req arriving in any state sets pending and is serviced at the next IDLE; an in-flight update completes first. inv_busy = pending || state==INV.
- Queued updates are retained across a sweep and processed after it.
- LRU touch: lu_hit_valid sets lru[lu_hit_index] = ~lu_hit_way. If the controller's LRU write targets the same set in the same cycle, the controller write wins.
- rst mid-operation returns everything to reset state next cycle. In-flight and queued updates are discarded.

Decomposition:
- Package btb_pkg holds:
  - width defaults
  - FSM state enum {IDLE, RD_WAIT, WRITE, INV}
  - index/tag extraction functions
  - update-entry struct {pc, target, taken}
- Sub-module btb_upd_fifo: parameterised QUEUE_DEPTH FIFO with full/empty flags and same-cycle push/pop.

Test Plan:
- Reset, then a single taken update, pc=0x0A4 target=0x1000, tags both invalid → rd_en at T+1 with index 2. Write at T+3: way0, index 2, tag 1, target 0x1000, vld 1. lru[2]=1.
- Two taken updates to set 2 with distinct tags while both ways are valid and lru[2]=0 → first writes way0 (lru[2]=1), second writes way1 (lru[2]=0).
- Not-taken update hitting way1 in set 5 → write way1 vld=0, lru[5]=1. Not-taken update that misses → no arr_wr_en and the queue pops.
- Hold lookup_active=1 for 4 cycles during WRITE → arr_wr_en stays 0 with stable payload, then fires the cycle lookup_active drops. Three back-to-back upd_valid → upd_ready falls when 2 entries are queued.
- inv_req mid-RD_WAIT with 1 update queued → current update writes first, then 16 vld=0 writes (index 0..7, way 0/1). inv_busy stays high throughout, then the queued update is processed.
- rst asserted in WRITE → no arr_wr_en next cycle, upd_ready=0 during rst, queue empty and all LRU bits 0 afterwards.

Source files
------------

// File: rtl/btb_pkg.sv
// BTB update controller shared types: widths, FSM states, update entry.
// Field helpers split a branch PC into set index and stored tag.
package btb_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int OFFSET_WIDTH = 4;
  localparam int INDEX_WIDTH  = 3;
  localparam int BRANCH_PC    = 10;
  localparam int TAG_WIDTH    = BRANCH_PC - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int QUEUE_DEPTH  = 2;
  localparam int NUM_SETS     = 1 << INDEX_WIDTH;
  localparam int INV_CNT_W    = INDEX_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WRITE,
    INV
  } state_e;

  typedef struct packed {
    logic [BRANCH_PC-1:0]  pc;
    logic [ADDR_WIDTH-1:0] target;
    logic                  taken;
  } upd_entry_t;

  localparam int ENTRY_W = $bits(upd_entry_t);

  function automatic logic [INDEX_WIDTH-1:0] pc_index(
    input logic [BRANCH_PC-1:0] pc
  );
    return pc[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
  endfunction

  function automatic logic [TAG_WIDTH-1:0] pc_tag(
    input logic [BRANCH_PC-1:0] pc
  );
    return pc[BRANCH_PC-1:OFFSET_WIDTH+INDEX_WIDTH];
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small FIFO for resolved-branch updates; same-cycle push and pop allowed.
// Ports: clk, rst (sync high), push/push_data, pop, head_data, full, empty.
module btb_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the counter alone defines which slots are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequences BTB array writes: queued EX updates, LRU upkeep, flush sweep.
// Ports: upd_* from EX, lookup_*/lu_* from fetch, inv_*, arr_rd_*/arr_wr_*.
module btb_update_ctrl
  import btb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [BRANCH_PC-1:0]   upd_pc,
  input  logic [ADDR_WIDTH-1:0]  upd_target,
  input  logic                   upd_taken,
  input  logic                   lookup_active,
  input  logic                   lu_hit_valid,
  input  logic [INDEX_WIDTH-1:0] lu_hit_index,
  input  logic                   lu_hit_way,
  input  logic                   inv_req,
  output logic                   inv_busy,
  output logic                   arr_rd_en,
  output logic [INDEX_WIDTH-1:0] arr_rd_index,
  input  logic [TAG_WIDTH-1:0]   arr_rd_tag0,
  input  logic [TAG_WIDTH-1:0]   arr_rd_tag1,
  input  logic                   arr_rd_vld0,
  input  logic                   arr_rd_vld1,
  output logic                   arr_wr_en,
  output logic                   arr_wr_way,
  output logic [INDEX_WIDTH-1:0] arr_wr_index,
  output logic [TAG_WIDTH-1:0]   arr_wr_tag,
  output logic [ADDR_WIDTH-1:0]  arr_wr_target,
  output logic                   arr_wr_vld
);

  state_e                 state_q, state_d;
  logic [INV_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [NUM_SETS-1:0]    lru_q, lru_d;
  logic                   wr_way_q, wr_way_d;
  logic [INDEX_WIDTH-1:0] wr_index_q, wr_index_d;
  logic [TAG_WIDTH-1:0]   wr_tag_q, wr_tag_d;
  logic [ADDR_WIDTH-1:0]  wr_target_q, wr_target_d;
  logic                   wr_vld_q, wr_vld_d;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ENTRY_W-1:0]     fifo_push_data;
  logic [ENTRY_W-1:0]     fifo_head_data;
  upd_entry_t             push_entry;
  upd_entry_t             head;
  logic [INDEX_WIDTH-1:0] head_idx;
  logic [TAG_WIDTH-1:0]   head_tag;

  logic                   hit0;
  logic                   hit1;
  logic                   sel_way;
  logic                   rd_go;
  logic                   wr_go;

  assign upd_ready = !fifo_full && !rst;
  assign fifo_push = upd_valid && upd_ready;

  always_comb begin
    push_entry        = '0;
    push_entry.pc     = upd_pc;
    push_entry.target = upd_target;
    push_entry.taken  = upd_taken;
  end

  assign fifo_push_data = push_entry;

  btb_upd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head_data (fifo_head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head     = upd_entry_t'(fifo_head_data);
  assign head_idx = pc_index(head.pc);
  assign head_tag = pc_tag(head.pc);

  assign hit0 = arr_rd_vld0 && (arr_rd_tag0 == head_tag);
  assign hit1 = arr_rd_vld1 && (arr_rd_tag1 == head_tag);

  // Hit way first (way0 wins a double hit), then first free way,
  // then the LRU victim of the set.
  always_comb begin
    sel_way = 1'b0;
    if (hit0) begin
      sel_way = 1'b0;
    end else if (hit1) begin
      sel_way = 1'b1;
    end else if (!arr_rd_vld0) begin
      sel_way = 1'b0;
    end else if (!arr_rd_vld1) begin
      sel_way = 1'b1;
    end else begin
      sel_way = lru_q[head_idx];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q || inv_req;
    lru_d       = lru_q;
    wr_way_d    = wr_way_q;
    wr_index_d  = wr_index_q;
    wr_tag_d    = wr_tag_q;
    wr_target_d = wr_target_q;
    wr_vld_d    = wr_vld_q;
    fifo_pop    = 1'b0;
    rd_go       = 1'b0;
    wr_go       = 1'b0;

    arr_wr_way    = wr_way_q;
    arr_wr_index  = wr_index_q;
    arr_wr_tag    = wr_tag_q;
    arr_wr_target = wr_target_q;
    arr_wr_vld    = wr_vld_q;

    // Fetch touch first so a same-set controller write below overrides it.
    if (lu_hit_valid) begin
      lru_d[lu_hit_index] = ~lu_hit_way;
    end

    unique case (state_q)
      IDLE: begin
        if (!lookup_active) begin
          if (pend_q) begin
            state_d = INV;
            cnt_d   = '0;
          end else if (!fifo_empty) begin
            rd_go   = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (!head.taken && !hit0 && !hit1) begin
          fifo_pop = 1'b1;
          state_d  = IDLE;
        end else begin
          wr_way_d    = sel_way;
          wr_index_d  = head_idx;
          wr_tag_d    = head_tag;
          wr_target_d = head.target;
          wr_vld_d    = head.taken;
          state_d     = WRITE;
        end
      end

      WRITE: begin
        if (!lookup_active) begin
          wr_go    = 1'b1;
          fifo_pop = 1'b1;
          lru_d[wr_index_q] = wr_vld_q ? ~wr_way_q : wr_way_q;
          state_d  = IDLE;
        end
      end

      INV: begin
        arr_wr_way    = cnt_q[0];
        arr_wr_index  = cnt_q[INV_CNT_W-1:1];
        arr_wr_tag    = '0;
        arr_wr_target = '0;
        arr_wr_vld    = 1'b0;
        if (!lookup_active) begin
          wr_go = 1'b1;
          cnt_d = cnt_q + INV_CNT_W'(1);
          if (cnt_q == '1) begin
            lru_d   = '0;
            // A request landing on the final write earns a fresh sweep.
            pend_d  = inv_req;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign arr_rd_en    = rd_go && !rst;
  assign arr_rd_index = rd_go ? head_idx : '0;
  assign arr_wr_en    = wr_go && !rst;
  assign inv_busy     = pend_q || (state_q == INV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      lru_q       <= '0;
      wr_way_q    <= 1'b0;
      wr_index_q  <= '0;
      wr_tag_q    <= '0;
      wr_target_q <= '0;
      wr_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      lru_q       <= lru_d;
      wr_way_q    <= wr_way_d;
      wr_index_q  <= wr_index_d;
      wr_tag_q    <= wr_tag_d;
      wr_target_q <= wr_target_d;
      wr_vld_q    <= wr_vld_d;
    end
  end

endmodule
